// File: rtl/uart_loader_pkg.sv
// Shared types for the UART word loader: FSM state encoding and word geometry.
package uart_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs incoming bytes into a little-endian 32-bit word; lane k is bits [8k+7:8k].
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid
);
    import uart_loader_pkg::*;

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  byte_idx;
    logic [31:0] asm_word;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            byte_idx <= '0;
            asm_word <= '0;
        end else if (byte_valid) begin
            asm_word[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx                          <= byte_idx + 2'd1;
        end
    end

    // Pulses with the byte that completes the word; the lane write lands the same edge.
    assign word_valid = byte_valid && (byte_idx == LAST_LANE);
    assign word_out   = asm_word;

endmodule

// File: rtl/uart_word_loader.sv
// Loads little-endian words assembled from UART bytes into memory at incrementing
// word addresses; used to program memory from the host before the CPU is released.
module uart_word_loader #(
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int NUM_WORDS   = 256,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       uart_data,
    input  logic              uart_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              timeout_err,
    output logic [ADDR_W:0]   word_count
);
    import uart_loader_pkg::*;

    localparam int                TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   NUM      = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);

    loader_state_t     state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   count, count_inc;
    logic [TW-1:0]     tcnt;
    logic              terr;
    logic              partial;
    logic              accept, pk_clear, tmo_fire, word_valid;
    logic [31:0]       word;
    logic              unused_hi;

    assign unused_hi = ^uart_data[31:8];
    assign count_inc = count + (ADDR_W + 1)'(1);

    // WRITE also accepts bytes so a byte landing on the write cycle starts the next word.
    assign accept   = uart_ready && !start && ((state == COLLECT) || (state == WRITE));
    assign tmo_fire = (state == COLLECT) && !start && !uart_ready && partial
                      && (tcnt == TMO_LAST);
    assign pk_clear = start || tmo_fire;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pk_clear),
        .byte_valid (accept),
        .byte_in    (uart_data[7:0]),
        .word_out   (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        busy      = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                if (start)           state_nxt = COLLECT;
                else if (tmo_fire)   state_nxt = IDLE;
                else if (word_valid) state_nxt = WRITE;
            end
            WRITE: begin
                busy   = 1'b1;
                mem_we = 1'b1;
                if (start)                 state_nxt = COLLECT;
                else if (count_inc == NUM) state_nxt = DONE;
                else                       state_nxt = COLLECT;
            end
            DONE: begin
                load_done = 1'b1;
                if (start) state_nxt = COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr    <= BASE;
            count   <= '0;
            terr    <= 1'b0;
            tcnt    <= '0;
            partial <= 1'b0;
        end else begin
            if (start) begin
                addr  <= BASE;
                count <= '0;
            end else if (state == WRITE) begin
                addr  <= addr + ADDR_W'(1);
                count <= count_inc;
            end

            if (start)         terr <= 1'b0;
            else if (tmo_fire) terr <= 1'b1;

            // Saturates at the last count; only fires when a word is partially built.
            if ((state != COLLECT) || uart_ready || start) tcnt <= '0;
            else if (tcnt != TMO_LAST)                     tcnt <= tcnt + TW'(1);

            if (pk_clear)    partial <= 1'b0;
            else if (accept) partial <= !word_valid;
        end
    end

    assign mem_addr    = addr;
    assign mem_wdata   = mem_we ? word : 32'h0;
    assign timeout_err = terr;
    assign word_count  = count;

endmodule
